// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand-bypass select generation and load-use stall detection for an
// in-order pipeline. The unit keeps its own shift register of destination
// tags for the instructions that have left ID, so nothing has to be routed
// back from the EX/MEM/WB pipeline registers.
//
// Forward selects are registered so that they line up with the instruction
// entering EX on the next edge. The stall output is combinational and feeds
// the PC and IF/ID write enables.
//
// Parameters
//   AW          register address width (register 0 is hardwired zero)
//   NSRC        source operands per instruction
//   DEPTH       tracked stages after ID (1 = EX ... DEPTH = WB), >= 2
//   LOAD_STAGE  stage whose output register first holds load data
//   CW          stall counter width
//   SELW        per-operand select width (derived)
//
// Ports
//   clk          clock
//   reset        synchronous, active-high
//   id_valid     ID holds a real instruction
//   id_src       source i at [i*AW +: AW]
//   id_src_used  source i is actually read
//   id_rd        destination register
//   id_regwrite  instruction writes id_rd
//   id_is_load   result comes from memory
//   flush        kill the ID instruction (branch taken)
//   stall        combinational; hold PC and IF/ID, insert bubble
//   ex_fwd_sel   registered per-operand select for the instruction in EX
//                (0 = regfile, DEPTH-s = output register of stage s)
//   ex_any_fwd   registered OR of all non-zero selects
//   stall_count  saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
   parameter  int AW         = 5,
   parameter  int NSRC       = 2,
   parameter  int DEPTH      = 3,
   parameter  int LOAD_STAGE = 2,
   parameter  int CW         = 16,
   localparam int SELW       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   id_valid,
   input  logic [NSRC*AW-1:0]     id_src,
   input  logic [NSRC-1:0]        id_src_used,
   input  logic [AW-1:0]          id_rd,
   input  logic                   id_regwrite,
   input  logic                   id_is_load,
   input  logic                   flush,
   output logic                   stall,
   output logic [NSRC*SELW-1:0]   ex_fwd_sel,
   output logic                   ex_any_fwd,
   output logic [CW-1:0]          stall_count
);

   // The WB entry of the tag pipe is never consulted (the regfile is
   // write-before-read), so only the EX..DEPTH-1 entries are stored.
   localparam int NT = DEPTH - 1;

   // Tag pipe, entry 0 = instruction currently in EX.
   logic [NT-1:0]          tag_v_q,  tag_v_d;
   logic [NT-1:0]          tag_wr_q, tag_wr_d;
   logic [NT-1:0]          tag_ld_q, tag_ld_d;
   logic [NT-1:0][AW-1:0]  tag_rd_q, tag_rd_d;

   logic [NSRC*SELW-1:0]   ex_fwd_sel_q, ex_fwd_sel_d;
   logic                   ex_any_fwd_q, ex_any_fwd_d;
   logic [CW-1:0]          stall_count_q, stall_count_d;

   logic [NSRC*SELW-1:0]   op_code_s;
   logic [NSRC-1:0]        op_haz_s;
   logic                   stall_s;
   logic                   insert_s;

   // Per-operand producer search: youngest matching writer decides the code.
   always_comb begin : hazard_detect
      logic [AW-1:0] src;
      logic          found;
      int            ready_stage;
      op_code_s   = '0;
      op_haz_s    = '0;
      src         = '0;
      found       = 1'b0;
      ready_stage = 1;
      for (int i = 0; i < NSRC; i++) begin
         src   = id_src[i*AW +: AW];
         found = 1'b0;
         if (id_src_used[i] && (src != '0)) begin
            for (int j = 0; j < NT; j++) begin
               if (!found && tag_v_q[j] && tag_wr_q[j] && (tag_rd_q[j] == src)) begin
                  found       = 1'b1;
                  ready_stage = tag_ld_q[j] ? LOAD_STAGE : 1;
                  // Entry j sits in stage j+1; its output register holds
                  // the result once the producing stage has been passed.
                  if (ready_stage <= (j + 1)) begin
                     op_code_s[i*SELW +: SELW] = SELW'(DEPTH - (j + 1));
                  end else begin
                     op_haz_s[i] = 1'b1;
                  end
               end else begin
                  found = found;
               end
            end
         end else begin
            op_haz_s[i] = 1'b0;
         end
      end
   end

   // Stall and insert qualification; flush kills the ID instruction outright.
   always_comb begin
      stall_s  = id_valid && !flush && (|op_haz_s);
      insert_s = id_valid && !stall_s && !flush;
   end

   // Next-state for the tag pipe, forward selects and stall counter.
   always_comb begin
      tag_v_d       = '0;
      tag_wr_d      = '0;
      tag_ld_d      = '0;
      tag_rd_d      = '0;
      ex_fwd_sel_d  = '0;
      ex_any_fwd_d  = 1'b0;
      stall_count_d = stall_count_q;

      // Entry 0 receives the ID instruction or a bubble; r0 writes never
      // produce a live tag so r0 is never forwarded and never stalls.
      tag_v_d[0]  = insert_s;
      tag_wr_d[0] = insert_s && id_regwrite && (id_rd != '0);
      tag_ld_d[0] = insert_s && id_is_load;
      tag_rd_d[0] = insert_s ? id_rd : '0;

      // Downstream stages never stall, so the pipe shifts every cycle.
      for (int k = 1; k < NT; k++) begin
         tag_v_d[k]  = tag_v_q[k-1];
         tag_wr_d[k] = tag_wr_q[k-1];
         tag_ld_d[k] = tag_ld_q[k-1];
         tag_rd_d[k] = tag_rd_q[k-1];
      end

      if (insert_s) begin
         ex_fwd_sel_d = op_code_s;
      end else begin
         ex_fwd_sel_d = '0;
      end
      ex_any_fwd_d = |ex_fwd_sel_d;

      if (stall_s && (stall_count_q != {CW{1'b1}})) begin
         stall_count_d = stall_count_q + CW'(1);
      end else begin
         stall_count_d = stall_count_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_v_q       <= '0;
         tag_wr_q      <= '0;
         tag_ld_q      <= '0;
         tag_rd_q      <= '0;
         ex_fwd_sel_q  <= '0;
         ex_any_fwd_q  <= 1'b0;
         stall_count_q <= '0;
      end else begin
         tag_v_q       <= tag_v_d;
         tag_wr_q      <= tag_wr_d;
         tag_ld_q      <= tag_ld_d;
         tag_rd_q      <= tag_rd_d;
         ex_fwd_sel_q  <= ex_fwd_sel_d;
         ex_any_fwd_q  <= ex_any_fwd_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall       = stall_s;
   assign ex_fwd_sel  = ex_fwd_sel_q;
   assign ex_any_fwd  = ex_any_fwd_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit. The reference model keeps a list of
// issued register writes stamped with the cycle they entered EX and derives
// stage position, readiness and forward source from those timestamps.
module tb_fwd_hazard_unit;

   localparam int AW = 5;
   localparam int DEPTH = 3;
   localparam int LOAD_STAGE = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_valid = 1'b0;
   logic [9:0]  id_src = '0;
   logic [1:0]  id_src_used = '0;
   logic [4:0]  id_rd = '0;
   logic        id_regwrite = 1'b0;
   logic        id_is_load = 1'b0;
   logic        flush = 1'b0;

   logic        stall, stall4;
   logic [3:0]  ex_fwd_sel, ex_fwd_sel4;
   logic        ex_any_fwd, ex_any_fwd4;
   logic [15:0] stall_count;
   logic [3:0]  stall_count4;

   fwd_hazard_unit #(.AW(AW), .NSRC(2), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CW(16)) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_is_load(id_is_load), .flush(flush), .stall(stall),
      .ex_fwd_sel(ex_fwd_sel), .ex_any_fwd(ex_any_fwd), .stall_count(stall_count)
   );

   fwd_hazard_unit #(.AW(AW), .NSRC(2), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CW(4)) u_dut4 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_is_load(id_is_load), .flush(flush), .stall(stall4),
      .ex_fwd_sel(ex_fwd_sel4), .ex_any_fwd(ex_any_fwd4), .stall_count(stall_count4)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         e;    // cycle in which the writer occupied EX
      logic [4:0] rd;
      bit         ld;
   } wr_t;

   typedef struct {
      logic        stall;
      logic [3:0]  sel;
      logic        any;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   wr_t   wq[$];
   exp_t  exp_q[$];

   int          mcyc = 0;
   int          m_cnt = 0;
   logic [3:0]  m_sel = '0;
   logic        m_any = 1'b0;
   bit          armed = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One ID cycle: drive inputs, evaluate the model, queue the expectation.
   task automatic cyc(input bit rst, input bit vld, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] used, input logic [4:0] rd, input bit rw, input bit ld,
                      input bit fl, output bit st);
      logic [1:0] cd [2];
      logic [4:0] src;
      bit         hz;
      bit         ins;
      int         best, age, need;
      exp_t       ex;
      @(negedge clk);
      reset = rst; id_valid = vld; id_src = {s1, s0}; id_src_used = used;
      id_rd = rd; id_regwrite = rw; id_is_load = ld; flush = fl;

      // Writers that have reached WB or beyond are served by the regfile.
      while (wq.size() > 0 && (mcyc - wq[0].e + 1) >= DEPTH) void'(wq.pop_front());

      hz = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cd[i] = 2'd0;
         src = (i == 0) ? s0 : s1;
         if (used[i] && src != 5'd0) begin
            best = -1;
            foreach (wq[k]) begin
               if (wq[k].rd == src && (best < 0 || wq[k].e > wq[best].e)) best = k;
            end
            if (best >= 0) begin
               age  = mcyc - wq[best].e + 1;         // stage the writer is in now
               need = wq[best].ld ? LOAD_STAGE : 1;  // stage whose output holds the result
               if (need <= age) cd[i] = 2'(DEPTH - age);
               else hz = 1'b1;
            end
         end
      end
      st = vld && !fl && hz;

      ex.stall = st; ex.sel = m_sel; ex.any = m_any;
      ex.cnt  = (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
      ex.cnt4 = (m_cnt > 15) ? 4'hf : 4'(m_cnt);
      if (armed) exp_q.push_back(ex);

      if (rst) begin
         wq.delete(); m_sel = '0; m_any = 1'b0; m_cnt = 0; armed = 1'b1;
      end else begin
         if (st) m_cnt++;
         ins = vld && !st && !fl;
         if (ins && rw && rd != 5'd0) wq.push_back('{mcyc + 1, rd, ld});
         m_sel = ins ? {cd[1], cd[0]} : 4'd0;
         m_any = (m_sel != 4'd0);
      end
      mcyc++;
   endtask

   // Issue an instruction and hold it in ID while the model says stall.
   task automatic insn(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic [4:0] rd, input bit rw, input bit ld);
      bit st;
      int n = 0;
      do begin
         cyc(1'b0, 1'b1, s0, s1, used, rd, rw, ld, 1'b0, st);
         n++;
      end while (st && n < 4);
      if (st) begin
         n_chk++;
         $display("FAIL stall_bound: got stall after %0d cycles expected release", n);
      end
   endtask

   task automatic nop();
      bit st;
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, st);
   endtask

   // Monitor: compares DUT outputs against the queued expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", stall, e.stall);
            chk("ex_fwd_sel", ex_fwd_sel, e.sel);
            chk("ex_any_fwd", ex_any_fwd, e.any);
            chk("stall_count", stall_count, e.cnt);
            chk("stall4", stall4, e.stall);
            chk("stall_count4", stall_count4, e.cnt4);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit st, hold;
      logic [4:0] r0s, r1s, rds;
      logic [1:0] us;
      bit rw, ld, vld, fl, rs;

      cyc(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, st);
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, st);
      nop();

      // sub r2 ; and r12,r2,r5
      insn(5'd3, 5'd4, 2'b11, 5'd2, 1'b1, 1'b0);
      insn(5'd2, 5'd5, 2'b11, 5'd12, 1'b1, 1'b0);
      nop(); nop();
      // sub r2 ; nop ; or r13,r6,r2 ; sub r2 ; add r3,r2,r2
      insn(5'd3, 5'd4, 2'b11, 5'd2, 1'b1, 1'b0);
      nop();
      insn(5'd6, 5'd2, 2'b11, 5'd13, 1'b1, 1'b0);
      insn(5'd3, 5'd4, 2'b11, 5'd2, 1'b1, 1'b0);
      insn(5'd2, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      nop(); nop();
      // lw r4 ; add r5,r4,r1
      insn(5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
      insn(5'd4, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0);
      nop(); nop();
      // same, with flush during the stall cycle
      insn(5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 5'd4, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0, 1'b1, st);
      nop(); nop();
      // load operand not used
      insn(5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
      insn(5'd4, 5'd1, 2'b10, 5'd5, 1'b1, 1'b0);
      nop(); nop();
      // writer to r0 then reader of r0
      insn(5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b1);
      insn(5'd0, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0);
      nop(); nop();
      // r7 ALU then r7 load then reader
      insn(5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0);
      insn(5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b1);
      insn(5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
      nop(); nop();
      // reset while a load-use stall is pending
      insn(5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 5'd4, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0, st);
      insn(5'd4, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0);
      nop();
      // drive the 4-bit counter into saturation
      for (int k = 0; k < 20; k++) begin
         insn(5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
         insn(5'd4, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0);
      end
      nop(); nop();

      // randomized traffic over a small register set to provoke hazards
      hold = 1'b0;
      r0s = '0; r1s = '0; rds = '0; us = '0; rw = 1'b0; ld = 1'b0; vld = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!hold) begin
            vld = ($urandom_range(0, 99) < 85);
            r0s = 5'($urandom_range(0, 3));
            r1s = 5'($urandom_range(0, 3));
            rds = 5'($urandom_range(0, 3));
            us  = 2'($urandom_range(0, 3));
            rw  = ($urandom_range(0, 99) < 80);
            ld  = ($urandom_range(0, 99) < 40);
         end
         fl = ($urandom_range(0, 99) < 8);
         rs = ($urandom_range(0, 199) == 0);
         cyc(rs, vld, r0s, r1s, us, rds, rw, ld, fl, st);
         hold = st;
      end
      nop(); nop();

      @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
